// File: rtl/lut_neuron_table_loader.sv
// ---------------------------------------------------------------------------
// lut_neuron_table_loader
//
// Purpose:
//    Runtime-writable LUT neuron. A neuron truth table is streamed in over a
//    valid/ready config port, stored in distributed RAM (one word per config
//    beat), and then served to lookups on the same interface a fixed-ROM
//    neuron presents. One instance per reprogrammable neuron in an hgcal
//    autoencoder layer, so table contents can change without a rebuild.
//
// Parameters:
//    IN_BITS   neuron input width; table depth is 2**IN_BITS entries
//    OUT_BITS  neuron output width (bits per table entry)
//    EPW       table entries packed per config word (must divide 2**IN_BITS)
//
// Ports:
//    clk        in   single clock, rising-edge logic
//    rst        in   synchronous active-high reset
//    cfg_valid  in   config beat valid
//    cfg_ready  out  config beat accepted when cfg_valid & cfg_ready
//    cfg_data   in   EPW packed entries; slice i is table[k*EPW+i] for beat k
//    cfg_last   in   marks the final beat of a load
//    in_valid   in   lookup request
//    M0         in   lookup address (neuron input vector)
//    out_valid  out  lookup result valid, one cycle after the request
//    M1         out  lookup result (neuron output)
//    loaded     out  table complete and usable
//    load_err   out  sticky: last load aborted on a framing/check error
//
// Build option:
//    LUT_LOAD_CHECKSUM_EN  when defined, every load carries one trailer beat
//                          after the table beats; its low CFG_W bits must be
//                          the XOR of all table beats and cfg_last belongs on
//                          the trailer. Ports are the same in both builds.
// ---------------------------------------------------------------------------
module lut_neuron_table_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int EPW      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [EPW*OUT_BITS-1:0]    cfg_data,
    input  logic                       cfg_last,
    input  logic                       in_valid,
    input  logic [IN_BITS-1:0]         M0,
    output logic                       out_valid,
    output logic [OUT_BITS-1:0]        M1,
    output logic                       loaded,
    output logic                       load_err
);

    localparam int CFG_W    = EPW * OUT_BITS;
    localparam int DEPTH    = 2 ** IN_BITS;
    localparam int NWORDS   = DEPTH / EPW;
    localparam int PTR_W    = $clog2(NWORDS) + 1;
    localparam int WIDX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int EPW_LOG2 = $clog2(EPW);
    localparam int SLOT_W   = (EPW > 1) ? EPW_LOG2 : 1;

    // Index of the beat that must carry cfg_last. With the checksum trailer
    // that is one past the last table word.
`ifdef LUT_LOAD_CHECKSUM_EN
    localparam logic [PTR_W-1:0] FINAL_IDX = PTR_W'(NWORDS);
`else
    localparam logic [PTR_W-1:0] FINAL_IDX = PTR_W'(NWORDS - 1);
`endif

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                r_state;
    logic [PTR_W-1:0]      r_ptr;
    logic                  r_loaded;
    logic                  r_load_err;
    logic                  r_out_valid;
    logic [OUT_BITS-1:0]   r_m1;
    logic [CFG_W-1:0]      r_mem [NWORDS];

`ifdef LUT_LOAD_CHECKSUM_EN
    logic [CFG_W-1:0]      r_csum;
`endif

    logic                  w_accept;
    logic [PTR_W-1:0]      w_beat_idx;
    logic                  w_final_beat;
    logic                  w_table_beat;
    logic                  w_check_ok;
    logic [WIDX_W-1:0]     w_rd_word_idx;
    logic [SLOT_W-1:0]     w_rd_slot;
    logic [CFG_W-1:0]      w_rd_word;
    logic [OUT_BITS-1:0]   w_rd_entry;

    // The loader can always absorb a beat: writes go straight into RAM, so
    // there is never a reason to stall the config stream.
    assign cfg_ready = 1'b1;
    assign w_accept  = cfg_valid & cfg_ready;

    // A beat arriving outside LOAD always starts a fresh load at word 0,
    // which is what makes a reload from ACTIVE or a retry after an error work.
    assign w_beat_idx   = (r_state == ST_LOAD) ? r_ptr : '0;
    assign w_final_beat = (w_beat_idx == FINAL_IDX);
    assign w_table_beat = (w_beat_idx < PTR_W'(NWORDS));

`ifdef LUT_LOAD_CHECKSUM_EN
    // The trailer is compared against the XOR of every table beat; the
    // running value is restarted by word 0 so stale loads never leak in.
    assign w_check_ok = (cfg_data == r_csum);
`else
    assign w_check_ok = 1'b1;
`endif

    // Lookup address split: upper bits pick the RAM word, lower bits pick
    // the entry inside the packed word.
    assign w_rd_word_idx = WIDX_W'(M0 >> EPW_LOG2);
    assign w_rd_slot     = (EPW > 1) ? SLOT_W'(M0) : '0;
    assign w_rd_word     = r_mem[w_rd_word_idx];
    assign w_rd_entry    = w_rd_word[int'(w_rd_slot) * OUT_BITS +: OUT_BITS];

    // Table RAM. No reset so it maps onto distributed RAM; only table beats
    // are written, never the checksum trailer.
    always_ff @(posedge clk) begin
        if (!rst && w_accept && w_table_beat) begin
            r_mem[w_beat_idx[WIDX_W-1:0]] <= cfg_data;
        end
    end

`ifdef LUT_LOAD_CHECKSUM_EN
    // Running XOR of table beats for the trailer check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_accept && w_table_beat) begin
            if (w_beat_idx == '0) begin
                r_csum <= cfg_data;
            end else begin
                r_csum <= r_csum ^ cfg_data;
            end
        end
    end
`endif

    // Load sequencing. The final beat always ends the load one way or the
    // other, so the word pointer can never run past FINAL_IDX. cfg_last
    // anywhere else, or missing on the final beat, aborts to EMPTY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_ptr      <= '0;
            r_loaded   <= 1'b0;
            r_load_err <= 1'b0;
        end else if (w_accept) begin
            if (w_final_beat) begin
                if (cfg_last && w_check_ok) begin
                    r_state    <= ST_ACTIVE;
                    r_ptr      <= '0;
                    r_loaded   <= 1'b1;
                    r_load_err <= 1'b0;
                end else begin
                    r_state    <= ST_EMPTY;
                    r_ptr      <= '0;
                    r_loaded   <= 1'b0;
                    r_load_err <= 1'b1;
                end
            end else if (cfg_last) begin
                r_state    <= ST_EMPTY;
                r_ptr      <= '0;
                r_loaded   <= 1'b0;
                r_load_err <= 1'b1;
            end else begin
                r_state  <= ST_LOAD;
                r_ptr    <= w_beat_idx + 1'b1;
                r_loaded <= 1'b0;
            end
        end
    end

    // Lookup pipeline. It is qualified by the registered loaded flag, so a
    // request on the same edge as a reload's first beat still completes and
    // sees the old word (the RAM write lands after this read).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_m1        <= '0;
        end else if (in_valid && r_loaded) begin
            r_out_valid <= 1'b1;
            r_m1        <= w_rd_entry;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign M1        = r_m1;
    assign loaded    = r_loaded;
    assign load_err  = r_load_err;

endmodule
